spectrum_bar_processor: RTL and testbench

Parametrised post-processor between the FFT and the graphics controller. It accepts one frame of NUM_BINS magnitude bins over a valid/ready handshake, and keeps a per-bin envelope that rises instantly and decays exponentially. It also keeps a per-bin peak-hold marker. It publishes both arrays atomically with a one-cycle done pulse, replacing the unconditional slow-clock bar latch.

---
 rtl/dav_pkg.sv | 13 +
 rtl/bar_envelope.sv | 61 ++++++
 rtl/spectrum_bar_processor.sv | 134 +++++++++++++
 tb/tb_spectrum_bar_processor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dav_pkg.sv
// Shared types for the spectrum bar post-processor.
// Peak hold is present only when SPECTRUM_PEAK_HOLD_EN is defined.
package dav_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    PUBLISH
  } bar_state_t;

  localparam int MIN_STEP = 1;

endpackage

// File: rtl/bar_envelope.sv
// Single-bin envelope / peak-hold update, purely combinational.
// Peak and hold ports exist only when SPECTRUM_PEAK_HOLD_EN is defined.
module bar_envelope
  import dav_pkg::*;
#(
`ifdef SPECTRUM_PEAK_HOLD_EN
  parameter int HOLD = 3,
  parameter int HW   = 2,
`endif
  parameter int W    = 12,
  parameter int DS   = 2
) (
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  l_i,
  input  logic          smooth_i,
`ifdef SPECTRUM_PEAK_HOLD_EN
  input  logic [W-1:0]  p_i,
  input  logic [HW-1:0] h_i,
  output logic [W-1:0]  p_o,
  output logic [HW-1:0] h_o,
`endif
  output logic [W-1:0]  l_o
);

  localparam logic [W-1:0] MIN = W'(MIN_STEP);

  logic [W-1:0] l_step;

  // Subtract only when the minuend is known larger, so nothing wraps.
  always_comb begin
    l_step = '0;
    l_o    = x_i;
    if (smooth_i && (x_i < l_i)) begin
      l_step = (l_i - x_i) >> DS;
      if (l_step < MIN) l_step = MIN;
      l_o = l_i - l_step;
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [W-1:0] p_step;

  always_comb begin
    p_step = '0;
    p_o    = p_i;
    h_o    = h_i;
    if (x_i >= p_i) begin
      p_o = x_i;
      h_o = HW'(HOLD);
    end else if (h_i != '0) begin
      h_o = h_i - HW'(1);
    end else begin
      p_step = p_i >> DS;
      if (p_step < MIN) p_step = MIN;
      p_o = p_i - p_step;
    end
    if (p_o < l_o) p_o = l_o;
  end
`endif

endmodule

// File: rtl/spectrum_bar_processor.sv
// Frame-based envelope and peak-hold bar processor with atomic publish.
// Define SPECTRUM_PEAK_HOLD_EN to enable peak tracking.
module spectrum_bar_processor
  import dav_pkg::*;
#(
  parameter int NUM_BINS    = 16,
  parameter int IN_W        = 12,
  parameter int OUT_W       = 12,
  parameter int DECAY_SHIFT = 2,
  parameter int HOLD_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_bins    [NUM_BINS],
  input  logic             smooth_en,
  output logic [OUT_W-1:0] level_bars [NUM_BINS],
  output logic [OUT_W-1:0] peak_bars  [NUM_BINS],
  output logic             frame_done
);

  localparam int IW = $clog2(NUM_BINS);
  localparam logic [IW-1:0] LAST = IW'(NUM_BINS - 1);

  bar_state_t state_q, state_d;

  logic [IW-1:0]   idx_q;
  logic [IN_W-1:0] buf_q  [NUM_BINS];
  logic            smooth_q;
  logic [IN_W-1:0] lvl_q  [NUM_BINS];
  logic [OUT_W-1:0] lbar_q [NUM_BINS];
  logic            done_q;
  logic [IN_W-1:0] lvl_n;

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  logic [IN_W-1:0]  pk_q   [NUM_BINS];
  logic [HW-1:0]    h_q    [NUM_BINS];
  logic [OUT_W-1:0] pbar_q [NUM_BINS];
  logic [IN_W-1:0]  pk_n;
  logic [HW-1:0]    h_n;

  bar_envelope #(
    .HOLD (HOLD_FRAMES),
    .HW   (HW),
    .W    (IN_W),
    .DS   (DECAY_SHIFT)
  ) u_env (
    .x_i      (buf_q[idx_q]),
    .l_i      (lvl_q[idx_q]),
    .smooth_i (smooth_q),
    .p_i      (pk_q[idx_q]),
    .h_i      (h_q[idx_q]),
    .p_o      (pk_n),
    .h_o      (h_n),
    .l_o      (lvl_n)
  );

  assign peak_bars = pbar_q;
`else
  bar_envelope #(
    .W  (IN_W),
    .DS (DECAY_SHIFT)
  ) u_env (
    .x_i      (buf_q[idx_q]),
    .l_i      (lvl_q[idx_q]),
    .smooth_i (smooth_q),
    .l_o      (lvl_n)
  );

  assign peak_bars = lbar_q;
`endif

  assign in_ready   = (state_q == IDLE);
  assign level_bars = lbar_q;
  assign frame_done = done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = PROC;
      PROC:    if (idx_q == LAST) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      smooth_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_BINS; i++) begin
        buf_q[i]  <= '0;
        lvl_q[i]  <= '0;
        lbar_q[i] <= '0;
`ifdef SPECTRUM_PEAK_HOLD_EN
        pk_q[i]   <= '0;
        h_q[i]    <= '0;
        pbar_q[i] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == PUBLISH);
      if (state_q == IDLE && in_valid) begin
        buf_q    <= in_bins;
        smooth_q <= smooth_en;
        idx_q    <= '0;
      end
      if (state_q == PROC) begin
        lvl_q[idx_q] <= lvl_n;
`ifdef SPECTRUM_PEAK_HOLD_EN
        pk_q[idx_q]  <= pk_n;
        h_q[idx_q]   <= h_n;
`endif
        if (idx_q != LAST) idx_q <= idx_q + IW'(1);
      end
      // Whole-frame copy keeps the outputs free of half-updated frames.
      if (state_q == PUBLISH) begin
        for (int i = 0; i < NUM_BINS; i++) begin
          lbar_q[i] <= lvl_q[i][IN_W-1 -: OUT_W];
`ifdef SPECTRUM_PEAK_HOLD_EN
          pbar_q[i] <= pk_q[i][IN_W-1 -: OUT_W];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_spectrum_bar_processor.sv
// Self-checking bench for spectrum_bar_processor (default parameters).
module tb_spectrum_bar_processor;

  localparam int N    = 16;
  localparam int W    = 12;
  localparam int DS   = 2;
  localparam int HOLD = 3;
`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  typedef logic [W-1:0] bins_t [N];

  typedef struct {
    bit         rst_before;
    logic [W-1:0] fill;
    bit         sm;
    logic [W-1:0] el;
    logic [W-1:0] ep;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  in_valid = 1'b0;
  logic  smooth_en = 1'b0;
  logic  in_ready;
  logic  frame_done;
  bins_t in_bins;
  bins_t level_bars;
  bins_t peak_bars;

  int tests = 0;
  int fails = 0;
  int mlvl [N];
  int mpk  [N];
  int mh   [N];

  always #5 clk = ~clk;

  spectrum_bar_processor #(
    .NUM_BINS    (N),
    .IN_W        (W),
    .OUT_W       (W),
    .DECAY_SHIFT (DS),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bins    (in_bins),
    .smooth_en  (smooth_en),
    .level_bars (level_bars),
    .peak_bars  (peak_bars),
    .frame_done (frame_done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      mlvl[b] = 0;
      mpk[b]  = 0;
      mh[b]   = 0;
    end
  endtask

  // Reference: attack instantly, release by a fraction of the gap.
  task automatic model_frame(input bins_t x, input bit sm);
    int xi;
    int dv;
    for (int b = 0; b < N; b++) begin
      xi = int'(x[b]);
      if (!sm || xi >= mlvl[b]) mlvl[b] = xi;
      else begin
        dv = (mlvl[b] - xi) / (1 << DS);
        mlvl[b] = mlvl[b] - imax(dv, 1);
      end
      if (xi >= mpk[b]) begin
        mpk[b] = xi;
        mh[b]  = HOLD;
      end else if (mh[b] > 0) begin
        mh[b] = mh[b] - 1;
      end else begin
        mpk[b] = mpk[b] - imax(mpk[b] / (1 << DS), 1);
      end
      mpk[b] = imax(mpk[b], mlvl[b]);
    end
  endtask

  task automatic check_model(input string nm);
    int bl = 0;
    int bp = 0;
    bit fl = 1'b0;
    bit fp = 1'b0;
    int ep;
    for (int b = 0; b < N; b++) begin
      ep = PK ? mpk[b] : mlvl[b];
      if (!fl && int'(level_bars[b]) != mlvl[b]) begin bl = b; fl = 1'b1; end
      if (!fp && int'(peak_bars[b]) != ep) begin bp = b; fp = 1'b1; end
    end
    chk({nm, " level"}, int'(level_bars[bl]), mlvl[bl]);
    chk({nm, " peak"}, int'(peak_bars[bp]), PK ? mpk[bp] : mlvl[bp]);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic run_frame(input bins_t x, input bit sm, input string nm);
    int n = 0;
    bit lowok = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({nm, " ready"}, int'(in_ready), 1);
    in_bins = x;
    smooth_en = sm;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!frame_done && n < 40) begin
      if (in_ready) lowok = 1'b0;
      in_bins[$urandom_range(0, N-1)] = W'($urandom);
      tick();
      n++;
    end
    chk({nm, " latency"}, n, 17);
    chk({nm, " busy"}, int'(lowok), 1);
    chk({nm, " ready@done"}, int'(in_ready), 1);
    model_frame(x, sm);
    check_model(nm);
    tick();
    chk({nm, " pulse"}, int'(frame_done), 0);
  endtask

  task automatic zero_check(input string nm);
    logic [W-1:0] acc = '0;
    for (int b = 0; b < N; b++) acc = acc | level_bars[b] | peak_bars[b];
    chk({nm, " bars"}, int'(acc), 0);
    chk({nm, " ready"}, int'(in_ready), 1);
    chk({nm, " done"}, int'(frame_done), 0);
  endtask

  vec_t  tv [8];
  bins_t va;
  bins_t vb;

  initial begin
    int n;
    int lowcnt;
    int dcnt;

    tv[0] = '{1'b0, 12'h800, 1'b1, 12'h800, 12'h800};
    tv[1] = '{1'b0, 12'h000, 1'b1, 12'h600, PK ? 12'h800 : 12'h600};
    tv[2] = '{1'b0, 12'h000, 1'b1, 12'h480, PK ? 12'h800 : 12'h480};
    tv[3] = '{1'b0, 12'h000, 1'b1, 12'h360, PK ? 12'h800 : 12'h360};
    tv[4] = '{1'b0, 12'h000, 1'b1, 12'h288, PK ? 12'h600 : 12'h288};
    tv[5] = '{1'b1, 12'h003, 1'b1, 12'h003, 12'h003};
    tv[6] = '{1'b0, 12'h000, 1'b1, 12'h002, PK ? 12'h003 : 12'h002};
    tv[7] = '{1'b0, 12'h000, 1'b0, 12'h000, PK ? 12'h003 : 12'h000};

    for (int b = 0; b < N; b++) in_bins[b] = '0;
    do_reset();
    zero_check("reset");

    for (int i = 0; i < 8; i++) begin
      if (tv[i].rst_before) do_reset();
      for (int b = 0; b < N; b++) va[b] = tv[i].fill;
      run_frame(va, tv[i].sm, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d lvl", i), int'(level_bars[i % N]), int'(tv[i].el));
      chk($sformatf("vec%0d pk", i), int'(peak_bars[(i * 5) % N]), int'(tv[i].ep));
    end

    // in_valid held high across two back-to-back frames
    for (int b = 0; b < N; b++) begin
      va[b] = W'($urandom);
      vb[b] = W'($urandom_range(0, 255));
    end
    in_bins = va;
    smooth_en = 1'b1;
    in_valid = 1'b1;
    tick();
    n = 0;
    lowcnt = 0;
    while (!frame_done && n < 40) begin
      if (!in_ready) lowcnt++;
      in_bins[$urandom_range(0, N-1)] = W'($urandom);
      tick();
      n++;
    end
    chk("hs1 latency", n, 17);
    chk("hs1 busy cycles", lowcnt, 17);
    model_frame(va, 1'b1);
    check_model("hs1");
    in_bins = vb;
    tick();
    chk("hs2 accepted", int'(in_ready), 0);
    chk("hs2 pulse", int'(frame_done), 0);
    n = 0;
    while (!frame_done && n < 40) begin
      in_bins[$urandom_range(0, N-1)] = W'($urandom);
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("hs2 latency", n, 17);
    model_frame(vb, 1'b1);
    check_model("hs2");
    tick();
    chk("hs no extra accept", int'(in_ready), 1);

    // reset while bin 7 is the next to be processed
    for (int b = 0; b < N; b++) in_bins[b] = W'($urandom);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    zero_check("midreset");
    tick();
    rst = 1'b1;
    dcnt = 0;
    repeat (25) begin
      tick();
      if (frame_done) dcnt++;
    end
    chk("midreset no done", dcnt, 0);
    model_reset();
    for (int b = 0; b < N; b++) va[b] = W'($urandom);
    run_frame(va, 1'b1, "post-reset");

    for (int f = 0; f < 20; f++) begin
      for (int b = 0; b < N; b++)
        va[b] = ($urandom % 3 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      run_frame(va, ($urandom % 4) != 0, $sformatf("rnd%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
